seq_det_ctrl: RTL

Programmable serial sequence-detection controller. It holds a run-time-configurable pattern of up to MAXLEN bits and supports overlapping and non-overlapping matching. It sequences a detection run through IDLE/RUN/DONE and counts matches up to a programmable limit. It is the configurable successor to the fixed-pattern Mealy detectors, driven by a host that loads the configuration, starts a run and waits for `done`.

---
 rtl/seq_det_ctrl.sv | 183 ++++++++++++++++++
 1 files changed

// File: rtl/seq_det_ctrl.sv
// seq_det_ctrl: programmable serial sequence detector.
// A host loads a pattern of 1..MAXLEN bits, then starts a run. Each data bit
// seen in RUN is shifted into a history register and compared with the pattern.
// The match flag is Mealy, so it is valid in the same cycle as the bit that
// completes the pattern. Matches are counted, optionally up to a limit; reaching
// the limit ends the run with a one-cycle done pulse.
module seq_det_ctrl #(
    parameter int MAXLEN = 8,
    parameter int CNTW   = 8,
    parameter int LW     = $clog2(MAXLEN) + 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cfg_we,
    input  logic [MAXLEN-1:0] cfg_pattern,
    input  logic [LW-1:0]     cfg_len,
    input  logic              cfg_overlap,
    input  logic [CNTW-1:0]   cfg_limit,
    input  logic              start,
    input  logic              stop,
    input  logic              data,
    output logic              detected,
    output logic              busy,
    output logic              done,
    output logic [CNTW-1:0]   match_count,
    output logic              cfg_err
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state_q, state_d;

    // Configuration, loaded only while idle.
    logic [MAXLEN-1:0] pat_q;
    logic [LW-1:0]     len_q;
    logic              ovl_q;
    logic [CNTW-1:0]   limit_q;

    // Run state: the last MAXLEN-1 data bits, how many of them are valid
    // history for the current match attempt, and the match counter.
    logic [MAXLEN-2:0] shreg_q;
    logic [LW-1:0]     fill_q;
    logic [CNTW-1:0]   count_q;
    logic              cfg_err_q;

    // Derived signals.
    logic [MAXLEN-1:0] window;
    logic [MAXLEN-1:0] len_mask;
    logic              cfg_len_ok;
    logic              cfg_accept;
    logic              pat_hit;
    logic              hist_ok;
    logic              match;
    logic              run_start;
    logic              limit_hit;
    logic [CNTW-1:0]   count_inc;
    logic [LW-1:0]     fill_inc;

    // The newest bit is the live input; older bits come from the history
    // register, so the oldest bit of the window sits at the MSB.
    assign window = {shreg_q, data};

    // Mask selecting the low len_q bits of the window and the pattern.
    always_comb begin
        // NOTE: every variable driven here gets a value on every path (the
        // default below), otherwise synthesis would infer a latch.
        len_mask = '0;
        for (int i = 0; i < MAXLEN; i++) begin
            len_mask[i] = (i < int'(len_q));
        end
    end

    assign cfg_len_ok = (cfg_len != '0) && (cfg_len <= LW'(MAXLEN));
    assign cfg_accept = cfg_we && (state_q == IDLE) && cfg_len_ok;

    // A match needs len-1 valid history bits plus the live bit. stop in the
    // same cycle suppresses the match so an aborted run never counts it.
    assign pat_hit = ((window ^ pat_q) & len_mask) == '0;
    assign hist_ok = fill_q >= (len_q - LW'(1));
    assign match   = (state_q == RUN) && !stop && hist_ok && pat_hit;

    assign run_start = (state_q == IDLE) && start && !stop;

    // Counter saturates at all-ones rather than wrapping back to zero.
    assign count_inc = (&count_q) ? count_q : count_q + CNTW'(1);
    assign fill_inc  = (fill_q == LW'(MAXLEN)) ? fill_q : fill_q + LW'(1);

    // A limit of zero means "run until stopped".
    assign limit_hit = match && (limit_q != '0) && (count_inc == limit_q);

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples the values from before this edge.
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (start && !stop) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                if (stop) begin
                    state_d = IDLE;
                end else if (limit_hit) begin
                    state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Output decode: the match flag is Mealy, the rest follow the state.
    always_comb begin
        detected    = match;
        busy        = (state_q == RUN);
        done        = (state_q == DONE);
        match_count = count_q;
        cfg_err     = cfg_err_q;
    end

    // Configuration registers; reset restores the single-bit zero pattern.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pat_q   <= '0;
            len_q   <= LW'(1);
            ovl_q   <= 1'b0;
            limit_q <= '0;
        end else if (cfg_accept) begin
            pat_q   <= cfg_pattern;
            len_q   <= cfg_len;
            ovl_q   <= cfg_overlap;
            limit_q <= cfg_limit;
        end
    end

    // Rejected configuration writes are flagged for exactly one cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cfg_err_q <= 1'b0;
        end else begin
            cfg_err_q <= cfg_we && !cfg_accept;
        end
    end

    // History, fill level and match counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shreg_q <= '0;
            fill_q  <= '0;
            count_q <= '0;
        end else if (run_start) begin
            shreg_q <= '0;
            fill_q  <= '0;
            count_q <= '0;
        end else if (state_q == RUN) begin
            shreg_q <= window[MAXLEN-2:0];
            if (match) begin
                count_q <= count_inc;
                // Non-overlapping mode discards the history so the next match
                // has to be built entirely from fresh bits.
                fill_q  <= ovl_q ? fill_inc : '0;
            end else begin
                fill_q  <= fill_inc;
            end
        end
    end

endmodule
